pc_sequencer: RTL

- Multicycle fetch/redirect controller for the bbtron core.
- Owns the program counter, runs the instruction-memory request/acknowledge handshake, and presents one instruction at a time to decode.
- Computes the next PC from one of three sources: sequential, J-type absolute (26-bit immediate zero-extended to 32 bits), or branch-relative/register target.
- Sits between instruction memory and the decode/sign-extension datapath.

---
 rtl/bbtron_pkg.sv | 20 ++
 rtl/jump_target_calc.sv | 37 +++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bbtron_pkg.sv
// Shared types and constants for the bbtron fetch front end.
package bbtron_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_HALT  = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      JK_ABS = 2'b00,
      JK_REL = 2'b01,
      JK_REG = 2'b10,
      JK_RSV = 2'b11
   } jump_kind_e;

endpackage

// File: rtl/jump_target_calc.sv
// Next-PC candidates: the sequential successor and the redirect target for a taken jump.
module jump_target_calc
   import bbtron_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int J_IMM_W = 26
)
(
   input  logic [ADDR_W-1:0]  pc,
   input  logic [1:0]         jump_kind,
   input  logic [J_IMM_W-1:0] jump_imm,
   input  logic [15:0]        branch_off,
   input  logic [ADDR_W-1:0]  reg_target,
   output logic [ADDR_W-1:0]  seq_pc,
   output logic [ADDR_W-1:0]  target_pc
);

   logic [ADDR_W-1:0] imm_ext;
   logic [ADDR_W-1:0] off_ext;

   // Branch offsets are relative to the successor, so the sequential adder feeds the branch adder.
   assign seq_pc  = pc + ADDR_W'(1);
   assign imm_ext = {{(ADDR_W-J_IMM_W){1'b0}}, jump_imm};
   assign off_ext = {{(ADDR_W-16){branch_off[15]}}, branch_off};

   always_comb begin
      // NOTE: give every always_comb output a default first so no path can infer a latch.
      target_pc = seq_pc;
      case (jump_kind_e'(jump_kind))
         JK_ABS: target_pc = imm_ext;
         JK_REL: target_pc = seq_pc + off_ext;
         JK_REG: target_pc = reg_target;
         JK_RSV: target_pc = seq_pc;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/redirect controller: owns the PC, runs the imem handshake, holds one instruction for decode.
module pc_sequencer
   import bbtron_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                J_IMM_W  = 26,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
)
(
   input  logic               clock,
   input  logic               reset,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        ir,
   output logic               ir_valid,
   input  logic               stall,
   input  logic               jump_en,
   input  logic [1:0]         jump_kind,
   input  logic [J_IMM_W-1:0] jump_imm,
   input  logic [15:0]        branch_off,
   input  logic [ADDR_W-1:0]  reg_target,
   input  logic               halt,
   output logic               halted,
   output logic [ADDR_W-1:0]  pc
);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              imem_req_q, imem_req_d;
   logic              halted_q, halted_d;

   logic [ADDR_W-1:0] seq_pc;
   logic [ADDR_W-1:0] target_pc;

   jump_target_calc #(
      .ADDR_W  (ADDR_W),
      .J_IMM_W (J_IMM_W)
   ) u_jump_target_calc (
      .pc         (pc_q),
      .jump_kind  (jump_kind),
      .jump_imm   (jump_imm),
      .branch_off (branch_off),
      .reg_target (reg_target),
      .seq_pc     (seq_pc),
      .target_pc  (target_pc)
   );

   // Outputs are registered and move in lock-step with the state, so they are glitch-free.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      imem_req_d = imem_req_q;
      halted_d   = halted_q;
      case (state_q)
         ST_BOOT: begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               ir_d       = imem_rdata;
               ir_valid_d = 1'b1;
               imem_req_d = 1'b0;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Retire: the only cycle in which the redirect and halt controls are looked at.
            if (!stall) begin
               ir_valid_d = 1'b0;
               if (halt) begin
                  halted_d = 1'b1;
                  state_d  = ST_HALT;
               end else begin
                  pc_d       = jump_en ? target_pc : seq_pc;
                  imem_req_d = 1'b1;
                  state_d    = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // NOTE: asynchronous reset clears every register the moment reset rises, dropping an in-flight request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         imem_req_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         imem_req_q <= imem_req_d;
         halted_q   <= halted_d;
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign ir        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign halted    = halted_q;

endmodule
